// File: rtl/decode_stage_pkg.sv
`default_nettype none
// ============================================================================
// Module      : decode_stage_pkg
// Description : Shared decode definitions: ALU operation codes, RV32I major
//               opcodes, src1 select codes, the decoded bundle layout and a
//               helper that maps arithmetic funct3 onto an ALU operation.
//               Reused by the ALU and the execute stage.
// Revision    : 1.0 - initial release
// ============================================================================
package decode_stage_pkg;

    // ALU operation codes; 14 and 15 are reserved and never produced
    localparam logic [3:0] c_alu_eq  = 4'd0;
    localparam logic [3:0] c_alu_ne  = 4'd1;
    localparam logic [3:0] c_alu_lt  = 4'd2;
    localparam logic [3:0] c_alu_ge  = 4'd3;
    localparam logic [3:0] c_alu_ltu = 4'd4;
    localparam logic [3:0] c_alu_geu = 4'd5;
    localparam logic [3:0] c_alu_add = 4'd6;
    localparam logic [3:0] c_alu_xor = 4'd7;
    localparam logic [3:0] c_alu_or  = 4'd8;
    localparam logic [3:0] c_alu_and = 4'd9;
    localparam logic [3:0] c_alu_sub = 4'd10;
    localparam logic [3:0] c_alu_sll = 4'd11;
    localparam logic [3:0] c_alu_srl = 4'd12;
    localparam logic [3:0] c_alu_sra = 4'd13;

    // RV32I major opcodes (instr[6:0])
    localparam logic [6:0] c_opc_op     = 7'b0110011;
    localparam logic [6:0] c_opc_op_imm = 7'b0010011;
    localparam logic [6:0] c_opc_branch = 7'b1100011;
    localparam logic [6:0] c_opc_load   = 7'b0000011;
    localparam logic [6:0] c_opc_store  = 7'b0100011;
    localparam logic [6:0] c_opc_lui    = 7'b0110111;
    localparam logic [6:0] c_opc_auipc  = 7'b0010111;
    localparam logic [6:0] c_opc_jal    = 7'b1101111;
    localparam logic [6:0] c_opc_jalr   = 7'b1100111;

    // First ALU operand select
    localparam logic [1:0] c_src1_rs1  = 2'b00;
    localparam logic [1:0] c_src1_pc   = 2'b01;
    localparam logic [1:0] c_src1_zero = 2'b10;

    typedef struct packed {
        logic [3:0]  alu_op;
        logic [31:0] imm;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [4:0]  rd;
        logic [1:0]  src1_sel;
        logic        src2_is_imm;
        logic        reg_write;
        logic        is_branch;
        logic        is_load;
        logic        is_store;
        logic        is_jump;
        logic        illegal;
    } dec_bundle_t;

    // Arithmetic funct3 -> ALU op. i_alt selects SUB (funct3=000) or
    // SRA (funct3=101); callers decide when the alternate form is allowed.
    function automatic logic [3:0] f_arith_op(input logic [2:0] i_funct3,
                                              input logic       i_alt);
        logic [3:0] r_op;
        case (i_funct3)
            3'b000:  r_op = i_alt ? c_alu_sub : c_alu_add;
            3'b001:  r_op = c_alu_sll;
            3'b010:  r_op = c_alu_lt;
            3'b011:  r_op = c_alu_ltu;
            3'b100:  r_op = c_alu_xor;
            3'b101:  r_op = i_alt ? c_alu_sra : c_alu_srl;
            3'b110:  r_op = c_alu_or;
            default: r_op = c_alu_and;
        endcase
        return r_op;
    endfunction

endpackage
`default_nettype wire

// File: rtl/decode_stage_imm_gen.sv
`default_nettype none
// ============================================================================
// Module      : imm_gen
// Description : Combinational RV32I immediate generator. Produces the
//               sign-extended I/S/B/U/J immediate selected by the opcode.
//               Shift-immediate forms return only the 5-bit shamt so the
//               funct7 bits never leak into the shift amount.
// Ports       : i_instr [DATA_WIDTH] instruction word
//               o_imm   [DATA_WIDTH] immediate (0 for R-type / unknown)
// Revision    : 1.0 - initial release
// ============================================================================
module imm_gen
    import decode_stage_pkg::*;
#(
    parameter int DATA_WIDTH = 32
) (
    input  logic [DATA_WIDTH-1:0] i_instr,
    output logic [DATA_WIDTH-1:0] o_imm
);

    logic [6:0] w_opcode;
    logic [2:0] w_funct3;

    assign w_opcode = i_instr[6:0];
    assign w_funct3 = i_instr[14:12];

    always_comb begin
        o_imm = '0;
        case (w_opcode)
            c_opc_op_imm: begin
                if (w_funct3 == 3'b001 || w_funct3 == 3'b101)
                    o_imm = {27'b0, i_instr[24:20]};
                else
                    o_imm = {{20{i_instr[31]}}, i_instr[31:20]};
            end
            c_opc_load, c_opc_jalr:
                o_imm = {{20{i_instr[31]}}, i_instr[31:20]};
            c_opc_store:
                o_imm = {{20{i_instr[31]}}, i_instr[31:25], i_instr[11:7]};
            c_opc_branch:
                o_imm = {{19{i_instr[31]}}, i_instr[31], i_instr[7],
                         i_instr[30:25], i_instr[11:8], 1'b0};
            c_opc_lui, c_opc_auipc:
                o_imm = {i_instr[31:12], 12'b0};
            c_opc_jal:
                o_imm = {{11{i_instr[31]}}, i_instr[31], i_instr[19:12],
                         i_instr[20], i_instr[30:21], 1'b0};
            default:
                o_imm = '0;
        endcase
    end

endmodule
`default_nettype wire

// File: rtl/decode_stage.sv
`default_nettype none
// ============================================================================
// Module      : decode_stage
// Description : RV32I decode pipeline stage. Decodes in_instr into ALU op,
//               operand selects, register indices, immediate and control
//               flags, and registers the result behind a valid/ready
//               handshake (one-cycle latency, full throughput).
// Ports       : clk, rst (async, active-high)
//               in_valid/in_instr/in_ready   upstream handshake
//               flush                        drop held + incoming bundle
//               out_valid/out_ready          downstream handshake
//               alu_op, imm, rs1, rs2, rd, src1_sel, src2_is_imm, reg_write,
//               is_branch, is_load, is_store, is_jump, illegal  bundle
// Revision    : 1.0 - initial release
// ============================================================================
module decode_stage
    import decode_stage_pkg::*;
#(
    parameter int DATA_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  in_valid,
    input  logic [DATA_WIDTH-1:0] in_instr,
    output logic                  in_ready,
    input  logic                  flush,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [3:0]            alu_op,
    output logic [DATA_WIDTH-1:0] imm,
    output logic [4:0]            rs1,
    output logic [4:0]            rs2,
    output logic [4:0]            rd,
    output logic [1:0]            src1_sel,
    output logic                  src2_is_imm,
    output logic                  reg_write,
    output logic                  is_branch,
    output logic                  is_load,
    output logic                  is_store,
    output logic                  is_jump,
    output logic                  illegal
);

    logic [6:0]      w_opcode;
    logic [2:0]      w_funct3;
    logic [6:0]      w_funct7;
    logic            w_f7_zero;
    logic            w_f7_alt;
    logic [31:0]     w_imm;
    logic            w_legal;
    logic            w_ready;
    logic            w_accept;
    dec_bundle_t     w_dec;
    dec_bundle_t     r_bundle;
    logic            r_valid;

    assign w_opcode  = in_instr[6:0];
    assign w_funct3  = in_instr[14:12];
    assign w_funct7  = in_instr[31:25];
    assign w_f7_zero = (w_funct7 == 7'b0000000);
    assign w_f7_alt  = (w_funct7 == 7'b0100000);

    imm_gen #(
        .DATA_WIDTH (DATA_WIDTH)
    ) u_imm_gen (
        .i_instr (in_instr),
        .o_imm   (w_imm)
    );

    // ------------------------------------------------------------------
    // Decode
    // ------------------------------------------------------------------
    always_comb begin
        w_dec          = '0;
        w_legal        = 1'b1;
        w_dec.alu_op   = c_alu_add;
        w_dec.imm      = w_imm;
        w_dec.rs1      = in_instr[19:15];
        w_dec.rs2      = in_instr[24:20];
        w_dec.rd       = in_instr[11:7];
        w_dec.src1_sel = c_src1_rs1;

        case (w_opcode)
            c_opc_op: begin
                w_dec.alu_op    = f_arith_op(w_funct3, w_f7_alt);
                w_dec.reg_write = 1'b1;
                // Only ADD/SUB and SRL/SRA have a funct7=0100000 form
                if (w_funct3 == 3'b000 || w_funct3 == 3'b101)
                    w_legal = w_f7_zero | w_f7_alt;
                else
                    w_legal = w_f7_zero;
            end
            c_opc_op_imm: begin
                // funct7 bit 5 is an opcode bit only for shifts right;
                // for funct3=000 it is immediate data, so no SUB here
                w_dec.alu_op      = f_arith_op(w_funct3,
                                               (w_funct3 == 3'b101) && w_f7_alt);
                w_dec.src2_is_imm = 1'b1;
                w_dec.reg_write   = 1'b1;
                if (w_funct3 == 3'b001)
                    w_legal = w_f7_zero;
                else if (w_funct3 == 3'b101)
                    w_legal = w_f7_zero | w_f7_alt;
            end
            c_opc_branch: begin
                w_dec.is_branch = 1'b1;
                case (w_funct3)
                    3'b000:  w_dec.alu_op = c_alu_eq;
                    3'b001:  w_dec.alu_op = c_alu_ne;
                    3'b100:  w_dec.alu_op = c_alu_lt;
                    3'b101:  w_dec.alu_op = c_alu_ge;
                    3'b110:  w_dec.alu_op = c_alu_ltu;
                    3'b111:  w_dec.alu_op = c_alu_geu;
                    default: w_legal      = 1'b0;
                endcase
            end
            c_opc_load: begin
                w_dec.src2_is_imm = 1'b1;
                w_dec.is_load     = 1'b1;
                w_dec.reg_write   = 1'b1;
                // LB/LH/LW/LBU/LHU only
                w_legal = (w_funct3 != 3'b011) && (w_funct3 != 3'b110) &&
                          (w_funct3 != 3'b111);
            end
            c_opc_store: begin
                w_dec.src2_is_imm = 1'b1;
                w_dec.is_store    = 1'b1;
                w_legal           = (w_funct3[2] == 1'b0) && (w_funct3 != 3'b011);
            end
            c_opc_lui: begin
                w_dec.src1_sel    = c_src1_zero;
                w_dec.src2_is_imm = 1'b1;
                w_dec.reg_write   = 1'b1;
            end
            c_opc_auipc: begin
                w_dec.src1_sel    = c_src1_pc;
                w_dec.src2_is_imm = 1'b1;
                w_dec.reg_write   = 1'b1;
            end
            c_opc_jal: begin
                w_dec.src1_sel    = c_src1_pc;
                w_dec.src2_is_imm = 1'b1;
                w_dec.is_jump     = 1'b1;
                w_dec.reg_write   = 1'b1;
            end
            c_opc_jalr: begin
                w_dec.src2_is_imm = 1'b1;
                w_dec.is_jump     = 1'b1;
                w_dec.reg_write   = 1'b1;
                w_legal           = (w_funct3 == 3'b000);
            end
            default: w_legal = 1'b0;
        endcase

        // Illegal encodings collapse to a harmless ADD with no side effects
        if (!w_legal) begin
            w_dec.alu_op      = c_alu_add;
            w_dec.imm         = '0;
            w_dec.src1_sel    = c_src1_rs1;
            w_dec.src2_is_imm = 1'b0;
            w_dec.reg_write   = 1'b0;
            w_dec.is_branch   = 1'b0;
            w_dec.is_load     = 1'b0;
            w_dec.is_store    = 1'b0;
            w_dec.is_jump     = 1'b0;
            w_dec.illegal     = 1'b1;
        end

        // x0 is hardwired; never request a write to it
        if (w_dec.rd == 5'd0)
            w_dec.reg_write = 1'b0;
    end

    // ------------------------------------------------------------------
    // Pipeline register
    // ------------------------------------------------------------------
    assign w_ready  = !r_valid || out_ready;
    assign w_accept = in_valid && w_ready && !flush;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_valid  <= 1'b0;
            r_bundle <= '0;
        end else if (flush) begin
            r_valid  <= 1'b0;
        end else if (w_accept) begin
            r_valid  <= 1'b1;
            r_bundle <= w_dec;
        end else if (out_ready) begin
            r_valid  <= 1'b0;
        end
    end

    // in_ready is forced low while reset is applied so every output reads 0
    assign in_ready    = !rst && w_ready;
    assign out_valid   = r_valid;
    assign alu_op      = r_bundle.alu_op;
    assign imm         = r_bundle.imm;
    assign rs1         = r_bundle.rs1;
    assign rs2         = r_bundle.rs2;
    assign rd          = r_bundle.rd;
    assign src1_sel    = r_bundle.src1_sel;
    assign src2_is_imm = r_bundle.src2_is_imm;
    assign reg_write   = r_bundle.reg_write;
    assign is_branch   = r_bundle.is_branch;
    assign is_load     = r_bundle.is_load;
    assign is_store    = r_bundle.is_store;
    assign is_jump     = r_bundle.is_jump;
    assign illegal     = r_bundle.illegal;

endmodule
`default_nettype wire

// File: tb/tb_decode_stage.sv
`default_nettype none
// ============================================================================
// Module      : tb_decode_stage
// Description : Directed self-checking bench for decode_stage. Inputs change
//               1 time unit after a rising edge; outputs are sampled there.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_decode_stage;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic [31:0] in_instr;
    logic        in_ready;
    logic        flush;
    logic        out_valid;
    logic        out_ready;
    logic [3:0]  alu_op;
    logic [31:0] imm;
    logic [4:0]  rs1, rs2, rd;
    logic [1:0]  src1_sel;
    logic        src2_is_imm, reg_write, is_branch, is_load, is_store, is_jump, illegal;

    int n_checks = 0;
    int n_fail   = 0;

    // {src2_is_imm, reg_write, is_branch, is_load, is_store, is_jump, illegal}
    logic [6:0]  w_flags;
    logic [61:0] w_all;
    assign w_flags = {src2_is_imm, reg_write, is_branch, is_load, is_store, is_jump, illegal};
    assign w_all   = {out_valid, in_ready, alu_op, imm, rs1, rs2, rd, src1_sel, w_flags};

    decode_stage #(.DATA_WIDTH(32)) dut (
        .clk         (clk),
        .rst         (rst),
        .in_valid    (in_valid),
        .in_instr    (in_instr),
        .in_ready    (in_ready),
        .flush       (flush),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .alu_op      (alu_op),
        .imm         (imm),
        .rs1         (rs1),
        .rs2         (rs2),
        .rd          (rd),
        .src1_sel    (src1_sel),
        .src2_is_imm (src2_is_imm),
        .reg_write   (reg_write),
        .is_branch   (is_branch),
        .is_load     (is_load),
        .is_store    (is_store),
        .is_jump     (is_jump),
        .illegal     (illegal)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    initial begin
        rst       = 1'b1;
        in_valid  = 1'b0;
        in_instr  = 32'h0;
        flush     = 1'b0;
        out_ready = 1'b1;

        // ---- reset state ----
        tick();
        tick();
        check("reset_all_zero", {2'b0, w_all}, 64'd0);
        rst = 1'b0;
        #1;
        check("post_reset_in_ready", {63'd0, in_ready}, 64'd1);
        check("post_reset_out_valid", {63'd0, out_valid}, 64'd0);

        // ---- ADD x3,x1,x2 ----
        in_valid = 1'b1;
        in_instr = 32'h002081B3;
        tick();
        check("add_valid", {63'd0, out_valid}, 64'd1);
        check("add_regs", {49'd0, rs1, rs2, rd}, {49'd0, 5'd1, 5'd2, 5'd3});
        check("add_alu", {60'd0, alu_op}, 64'd6);
        check("add_flags", {57'd0, w_flags}, {57'd0, 7'b0100000});

        // ---- SRAI x5,x6,3 (back-to-back, no bubble) ----
        in_instr = 32'h40335293;
        tick();
        check("srai_valid", {63'd0, out_valid}, 64'd1);
        check("srai_alu_imm_rd", {23'd0, alu_op, imm, rd}, {23'd0, 4'd13, 32'd3, 5'd5});
        check("srai_flags", {57'd0, w_flags}, {57'd0, 7'b1100000});

        // ---- BLTU x1,x2,+8 ----
        in_instr = 32'h0020E463;
        tick();
        check("bltu_alu_imm", {28'd0, alu_op, imm}, {28'd0, 4'd4, 32'd8});
        check("bltu_flags", {57'd0, w_flags}, {57'd0, 7'b0010000});

        // ---- LUI x1,0x12345 ----
        in_instr = 32'h123450B7;
        tick();
        check("lui_imm", {32'd0, imm}, {32'd0, 32'h12345000});
        check("lui_src1_alu", {58'd0, src1_sel, alu_op}, {58'd0, 2'b10, 4'd6});
        check("lui_flags", {57'd0, w_flags}, {57'd0, 7'b1100000});

        // ---- SUB x3,x1,x2 ----
        in_instr = 32'h402081B3;
        tick();
        check("sub_alu", {60'd0, alu_op}, 64'd10);

        // ---- SW x2,8(x1) ----
        in_instr = 32'h0020A423;
        tick();
        check("sw_alu_imm", {28'd0, alu_op, imm}, {28'd0, 4'd6, 32'd8});
        check("sw_flags", {57'd0, w_flags}, {57'd0, 7'b1000100});

        // ---- ADDI x1,x0,-1 : sign extension ----
        in_instr = 32'hFFF00093;
        tick();
        check("addi_neg_imm", {32'd0, imm}, {32'd0, 32'hFFFFFFFF});

        // ---- ADDI x0,x0,0 : rd=0 suppresses reg_write ----
        in_instr = 32'h00000013;
        tick();
        check("nop_flags", {57'd0, w_flags}, {57'd0, 7'b1000000});

        // ---- JAL x1,+16 ----
        in_instr = 32'h010000EF;
        tick();
        check("jal_imm_src1", {30'd0, src1_sel, imm}, {30'd0, 2'b01, 32'd16});
        check("jal_flags", {57'd0, w_flags}, {57'd0, 7'b1100010});

        // ---- unknown opcode ----
        in_instr = 32'hFFFFFFFF;
        tick();
        check("illegal_opc", {21'd0, alu_op, imm, w_flags}, {21'd0, 4'd6, 32'd0, 7'b0000001});

        // ---- SLL with funct7=0100000 is undefined ----
        in_instr = 32'h402091B3;
        tick();
        check("illegal_sll_f7", {53'd0, alu_op, w_flags}, {53'd0, 4'd6, 7'b0000001});

        // ---- drain ----
        in_valid = 1'b0;
        tick();
        check("drain_out_valid", {63'd0, out_valid}, 64'd0);

        // ---- backpressure: hold for 3 cycles ----
        in_valid = 1'b1;
        in_instr = 32'h002081B3;
        tick();
        out_ready = 1'b0;
        in_instr  = 32'h402081B3;
        #1;
        check("bp_in_ready_low", {63'd0, in_ready}, 64'd0);
        for (int i = 0; i < 3; i++) begin
            tick();
            check("bp_hold", {54'd0, out_valid, in_ready, alu_op, rd},
                  {54'd0, 1'b1, 1'b0, 4'd6, 5'd3});
        end
        out_ready = 1'b1;
        tick();
        check("bp_release_next", {59'd0, out_valid, alu_op}, {59'd0, 1'b1, 4'd10});
        in_valid = 1'b0;
        tick();
        check("bp_no_duplicate", {63'd0, out_valid}, 64'd0);

        // ---- flush ----
        in_valid = 1'b1;
        in_instr = 32'h002081B3;
        tick();
        check("flush_pre_valid", {63'd0, out_valid}, 64'd1);
        flush     = 1'b1;
        in_instr  = 32'h402081B3;
        out_ready = 1'b0;
        tick();
        check("flush_clears", {63'd0, out_valid}, 64'd0);
        check("flush_no_accept", {60'd0, alu_op}, 64'd6);
        flush     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        tick();
        check("flush_stays_empty", {63'd0, out_valid}, 64'd0);

        // ---- asynchronous reset mid-stream ----
        in_valid = 1'b1;
        in_instr = 32'hFFF00093;
        tick();
        check("rst_pre_valid", {63'd0, out_valid}, 64'd1);
        #2;
        rst = 1'b1;
        #1;
        check("rst_async_zero", {2'b0, w_all}, 64'd0);
        tick();
        rst      = 1'b0;
        in_valid = 1'b0;
        #1;
        check("rst_release_ready", {62'd0, in_ready, out_valid}, {62'd0, 2'b10});

        // ---- decode works after reset ----
        in_valid = 1'b1;
        in_instr = 32'h123450B7;
        tick();
        check("post_rst_lui", {31'd0, out_valid, imm}, {31'd0, 1'b1, 32'h12345000});
        in_valid = 1'b0;
        tick();

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/decode_stage.md
DECODE_STAGE -- requirements
Module: decode_stage

Interface
REQ-001 The block SHALL have parameter DATA_WIDTH, default 32, giving the instruction and immediate width; only 32 is supported.
REQ-002 clk  input  1  sole clock; all state updates on the rising edge.
REQ-003 rst  input  1  asynchronous, active-high reset.
REQ-004 in_valid  input  1  instruction word present on in_instr.
REQ-005 in_instr  input  32  RV32I instruction word.
REQ-006 in_ready  output  1  stage accepts in_instr this cycle.
REQ-007 flush  input  1  discard the held and incoming instruction.
REQ-008 out_valid  output  1  decoded bundle valid.
REQ-009 out_ready  input  1  downstream consumes the bundle this cycle.
REQ-010 alu_op  output  4  ALU operation code per REQ-016.
REQ-011 imm  output  32  sign-extended immediate.
REQ-012 rs1, rs2, rd  output  5 each  register indices.
REQ-013 src1_sel  output  2  00 = rs1, 01 = PC, 10 = zero.
REQ-014 src2_is_imm, reg_write, is_branch, is_load, is_store, is_jump, illegal  output  1 each  control flags.

Function
REQ-015 The stage SHALL be a single registered pipeline stage: a bundle accepted in cycle N appears on the outputs in cycle N+1.
REQ-016 alu_op encoding SHALL be: 0 EQ, 1 NE, 2 LT, 3 GE, 4 LTU, 5 GEU, 6 ADD, 7 XOR, 8 OR, 9 AND, 10 SUB, 11 SLL, 12 SRL, 13 SRA; codes 14-15 are never driven.
REQ-017 Acceptance SHALL occur when in_valid && in_ready, with in_ready = !out_valid || out_ready, giving full throughput with no bubble under continuous out_ready.
REQ-018 While out_valid && !out_ready, all outputs SHALL hold stable.
REQ-019 R-type (0110011) SHALL map funct3/funct7 to ADD/SUB/SLL/LT/LTU/XOR/SRL/SRA/OR/AND, with src2_is_imm=0 and reg_write=1.
REQ-020 OP-IMM (0010011) SHALL decode like R-type with src2_is_imm=1. funct7 bit 5 SHALL select SRA only for funct3=101. SUB is never produced.
REQ-021 BRANCH (1100011) SHALL map funct3 000/001/100/101/110/111 to EQ/NE/LT/GE/LTU/GEU, with is_branch=1, reg_write=0, and B-immediate.
REQ-022 LOAD and STORE SHALL decode as follows:
- LOAD (0000011): alu_op=ADD, src2_is_imm=1, is_load=1, reg_write=1.
- STORE (0100011): alu_op=ADD, S-immediate, is_store=1, reg_write=0.
REQ-023 LUI SHALL decode as src1_sel=zero and AUIPC as src1_sel=PC; both use ADD, U-immediate, and reg_write=1.
REQ-024 JAL/JALR SHALL set is_jump=1, alu_op=ADD, and reg_write=1. JAL uses src1_sel=PC with J-immediate; JALR uses rs1 with I-immediate.
REQ-025 An unlisted opcode, or an undefined funct3/funct7 combination, SHALL produce illegal=1, reg_write=0, all other flags 0, and alu_op=ADD.
REQ-026 reg_write SHALL be forced to 0 when rd=0.
REQ-027 flush SHALL clear out_valid on the next edge and SHALL suppress acceptance in the same cycle, overriding in_valid and out_ready.

Reset
REQ-028 While rst is high, out_valid SHALL be 0 and every other output SHALL be 0.
REQ-029 Reset asserted mid-transfer SHALL drop the held bundle asynchronously.
REQ-030 After rst deasserts, in_ready SHALL be 1 in the first cycle.

Structure
REQ-031 A shared package SHALL hold the alu_op codes, the opcode constants, and the src1_sel codes, for reuse by the ALU and the execute stage.
REQ-032 The combinational decode SHALL be a sub-module, imm_gen, that produces the immediate from the instruction.
REQ-033 The remaining decode logic and the pipeline register SHALL live in decode_stage.

Verification
REQ-034 ADD x3,x1,x2, in_instr=0x002081B3 -> next cycle alu_op=6, rs1=1, rs2=2, rd=3, reg_write=1, src2_is_imm=0.
REQ-035 SRAI x5,x6,3, in_instr=0x40335293 -> alu_op=13, imm=3, src2_is_imm=1, rd=5.
REQ-036 BLTU x1,x2,+8, in_instr=0x0020E463 -> alu_op=4, imm=8, is_branch=1, reg_write=0.
REQ-037 LUI x1,0x12345, in_instr=0x123450B7 -> imm=0x12345000, src1_sel=10, alu_op=6.
REQ-038 Backpressure: hold out_ready=0 for 3 cycles with in_valid=1 -> outputs stable, in_ready=0, and no instruction is lost or duplicated once out_ready=1.
REQ-039 Flush and reset: assert flush with out_valid=1 -> out_valid=0 next cycle. Pulse rst mid-stream -> all outputs 0 immediately.
